// File: rtl/cpu_writeback_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_writeback_fifo                                                       |
// | Multi-source writeback queue feeding the register-file write port.       |
// | Optional macro WB_FIFO_PENDING_MASK_EN adds a registered pending_mask.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cpu_writeback_fifo #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*REG_W-1:0]      src_dest_reg,
  input  logic [NUM_SRC*DATA_W-1:0]     src_data,
  output logic                          src_ready,
  input  logic                          cpu_ready,
  output logic                          out_valid,
  output logic [REG_W-1:0]              out_dest_reg,
  output logic [DATA_W-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy,
`ifdef WB_FIFO_PENDING_MASK_EN
  output logic [2**REG_W-1:0]           pending_mask,
`endif
  output logic                          overflow
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH+1);
  localparam int c_SUM_W = c_CNT_W + 1;

  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_overflow;
  logic [REG_W-1:0]   r_mem_dest [DEPTH];
  logic [DATA_W-1:0]  r_mem_data [DEPTH];

  logic               w_pop;
  logic [c_SUM_W-1:0] w_space;
  logic [c_SUM_W-1:0] w_acc;
  logic               w_drop;
  logic [c_PTR_W-1:0] w_slot;
  logic [DEPTH-1:0]   w_wr_en;
  logic [REG_W-1:0]   w_wr_dest [DEPTH];
  logic [DATA_W-1:0]  w_wr_data [DEPTH];
  logic [c_CNT_W-1:0] w_count_next;
  logic [c_PTR_W-1:0] w_rd_ptr_next;
  logic [c_PTR_W-1:0] w_wr_ptr_next;

  assign w_pop   = (r_count != '0) && cpu_ready;
  // A pop in the same cycle frees its slot for an incoming push.
  assign w_space = c_SUM_W'(DEPTH) - c_SUM_W'(r_count) + c_SUM_W'(w_pop);

  always_comb begin
    w_acc     = '0;
    w_drop    = 1'b0;
    w_slot    = '0;
    w_wr_en   = '0;
    w_wr_dest = '{default: '0};
    w_wr_data = '{default: '0};
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i] && (src_dest_reg[i*REG_W +: REG_W] != '0)) begin
        if (w_acc < w_space) begin
          w_slot            = r_wr_ptr + w_acc[c_PTR_W-1:0];
          w_wr_en[w_slot]   = 1'b1;
          w_wr_dest[w_slot] = src_dest_reg[i*REG_W +: REG_W];
          w_wr_data[w_slot] = src_data[i*DATA_W +: DATA_W];
          w_acc             = w_acc + c_SUM_W'(1);
        end else begin
          w_drop = 1'b1;
        end
      end
    end
  end

  assign w_count_next  = c_CNT_W'(c_SUM_W'(r_count) - c_SUM_W'(w_pop) + w_acc);
  assign w_rd_ptr_next = r_rd_ptr + c_PTR_W'(w_pop);
  assign w_wr_ptr_next = r_wr_ptr + w_acc[c_PTR_W-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_rd_ptr   <= w_rd_ptr_next;
      r_wr_ptr   <= w_wr_ptr_next;
      r_count    <= w_count_next;
      r_overflow <= r_overflow | w_drop;
    end
  end

  // Payload storage is intentionally left out of reset.
  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    always_ff @(posedge clock) begin
      if (w_wr_en[k]) begin
        r_mem_dest[k] <= w_wr_dest[k];
        r_mem_data[k] <= w_wr_data[k];
      end
    end
  end

`ifdef WB_FIFO_PENDING_MASK_EN
  logic [2**REG_W-1:0] r_pending_mask;
  logic [2**REG_W-1:0] w_mask_next;
  logic [c_PTR_W-1:0]  w_off;

  // Mask reflects the entries that will be held after this edge.
  always_comb begin
    w_mask_next = '0;
    w_off       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_off = c_PTR_W'(k) - w_rd_ptr_next;
      if (c_CNT_W'(w_off) < w_count_next) begin
        if (w_wr_en[k]) begin
          w_mask_next[w_wr_dest[k]] = 1'b1;
        end else begin
          w_mask_next[r_mem_dest[k]] = 1'b1;
        end
      end
    end
    w_mask_next[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pending_mask <= '0;
    end else begin
      r_pending_mask <= w_mask_next;
    end
  end

  assign pending_mask = r_pending_mask;
`endif

  assign out_valid    = (r_count != '0);
  assign out_dest_reg = out_valid ? r_mem_dest[r_rd_ptr] : '0;
  assign out_data     = out_valid ? r_mem_data[r_rd_ptr] : '0;
  assign occupancy    = r_count;
  assign overflow     = r_overflow;
  assign src_ready    = (c_SUM_W'(DEPTH) - c_SUM_W'(r_count)) >= c_SUM_W'(NUM_SRC);

endmodule
`default_nettype wire

// File: tb/tb_cpu_writeback_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpu_writeback_fifo                                                    |
// | Scoreboard bench with a queue-based reference model.                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cpu_writeback_fifo;

  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 4;
  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;

  typedef struct packed {
    logic [REG_W-1:0]  d;
    logic [DATA_W-1:0] x;
  } ent_t;

  logic                         clock = 1'b0;
  logic                         reset = 1'b1;
  logic [NUM_SRC-1:0]           src_valid = '0;
  logic [NUM_SRC*REG_W-1:0]     src_dest_reg = '0;
  logic [NUM_SRC*DATA_W-1:0]    src_data = '0;
  logic                         src_ready;
  logic                         cpu_ready = 1'b0;
  logic                         out_valid;
  logic [REG_W-1:0]             out_dest_reg;
  logic [DATA_W-1:0]            out_data;
  logic [$clog2(DEPTH+1)-1:0]   occupancy;
  logic                         overflow;
`ifdef WB_FIFO_PENDING_MASK_EN
  logic [2**REG_W-1:0]          pending_mask;
`endif

  ent_t exp_q[$];
  logic model_ovf = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  cpu_writeback_fifo #(
    .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .src_valid(src_valid),
    .src_dest_reg(src_dest_reg),
    .src_data(src_data),
    .src_ready(src_ready),
    .cpu_ready(cpu_ready),
    .out_valid(out_valid),
    .out_dest_reg(out_dest_reg),
    .out_data(out_data),
    .occupancy(occupancy),
`ifdef WB_FIFO_PENDING_MASK_EN
    .pending_mask(pending_mask),
`endif
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [2**REG_W-1:0] model_mask();
    logic [2**REG_W-1:0] m;
    m = '0;
    foreach (exp_q[k]) m[exp_q[k].d] = 1'b1;
    return m;
  endfunction

  // Monitor: compares presented outputs with the model, then retires the head.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      check("out_valid", out_valid, exp_q.size() != 0);
      check("occupancy", occupancy, exp_q.size());
      check("src_ready", src_ready, (DEPTH - exp_q.size()) >= NUM_SRC);
      check("overflow", overflow, model_ovf);
`ifdef WB_FIFO_PENDING_MASK_EN
      check("pending_mask", pending_mask, model_mask());
`endif
      if (exp_q.size() != 0) begin
        check("out_dest_reg", out_dest_reg, exp_q[0].d);
        check("out_data", out_data, exp_q[0].x);
        if (cpu_ready) void'(exp_q.pop_front());
      end else begin
        check("idle_dest_reg", out_dest_reg, 0);
        check("idle_data", out_data, 0);
      end
    end
  end

  // Drives one cycle of stimulus and records what the queue should accept.
  task automatic step(input logic [NUM_SRC-1:0] v, input logic [NUM_SRC*REG_W-1:0] d,
                      input logic [NUM_SRC*DATA_W-1:0] x, input logic r);
    int   space;
    ent_t e;
    @(negedge clock);
    src_valid    = v;
    src_dest_reg = d;
    src_data     = x;
    cpu_ready    = r;
    #2;
    space = DEPTH - exp_q.size();
    for (int i = 0; i < NUM_SRC; i++) begin
      if (v[i] && d[i*REG_W +: REG_W] != '0) begin
        if (space > 0) begin
          e.d = d[i*REG_W +: REG_W];
          e.x = x[i*DATA_W +: DATA_W];
          exp_q.push_back(e);
          space--;
        end else begin
          model_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input logic r, input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, r);
  endtask

  task automatic reset_mid();
    @(posedge clock);
    #2;
    reset     = 1'b0;
    src_valid = '0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_overflow", overflow, 0);
`ifdef WB_FIFO_PENDING_MASK_EN
    check("rst_pending_mask", pending_mask, 0);
`endif
    exp_q.delete();
    model_ovf = 1'b0;
    @(negedge clock);
    #3;
    reset = 1'b1;
  endtask

  initial begin
    logic [NUM_SRC-1:0]        v;
    logic [NUM_SRC*REG_W-1:0]  d;
    logic [NUM_SRC*DATA_W-1:0] x;
    #1 reset = 1'b0;
    @(negedge clock);
    #3 reset = 1'b1;
    idle(1'b0, 2);

    // Single push, one-cycle latency, immediate pop.
    step(2'b01, {5'd0, 5'd3}, {32'h0, 32'h11111111}, 1'b1);
    idle(1'b1, 2);

    // Two same-cycle pushes held, then released in source order.
    step(2'b11, {5'd6, 5'd5}, {32'hB, 32'hA}, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 3);

    // Fill, overflow drop, then push into slot freed by pop while full.
    step(2'b11, {5'd2, 5'd1}, {32'h22, 32'h21}, 1'b0);
    step(2'b11, {5'd4, 5'd3}, {32'h44, 32'h43}, 1'b0);
    step(2'b11, {5'd8, 5'd7}, {32'h88, 32'h77}, 1'b0);
    idle(1'b0, 1);
    step(2'b01, {5'd0, 5'd9}, {32'h0, 32'h99}, 1'b1);
    idle(1'b1, 6);

    // Register 0 results are discarded without overflow.
    reset_mid();
    step(2'b01, {5'd0, 5'd0}, {32'h0, 32'hDEAD}, 1'b0);
    step(2'b11, {5'd0, 5'd0}, {32'h1, 32'h2}, 1'b1);
    idle(1'b1, 2);

    // Six entries through the wrapping pointers, then reset mid-stream.
    for (int k = 0; k < 6; k++)
      step(2'b01, {5'd0, 5'(10 + k)}, {32'h0, 32'h100 + 32'(k)}, 1'(k % 2));
    idle(1'b1, 1);
    step(2'b11, {5'd21, 5'd20}, {32'h2021, 32'h2020}, 1'b0);
    reset_mid();
    idle(1'b1, 1);

    // Randomized traffic including src_ready violations and reg-0 results.
    for (int c = 0; c < 400; c++) begin
      v = NUM_SRC'($urandom);
      for (int i = 0; i < NUM_SRC; i++) begin
        d[i*REG_W +: REG_W]  = ($urandom_range(0, 7) == 0) ? '0 : REG_W'($urandom_range(1, 2**REG_W - 1));
        x[i*DATA_W +: DATA_W] = $urandom;
      end
      step(v, d, x, $urandom_range(0, 3) != 0);
      if (c == 200) reset_mid();
    end
    idle(1'b1, DEPTH + 2);
    reset_mid();
    idle(1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
